// File: rtl/serial_onehot_rx_pkg.sv
// Shared state encoding and output-mode constants for the serial one-hot receiver.
package serial_onehot_rx_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_RECV      = 2'd1,
    ST_WAIT_STOP = 2'd2,
    ST_DISCARD   = 2'd3
  } state_e;

  localparam int MODE_ONEHOT = 0;
  localparam int MODE_RAW    = 1;

endpackage

// File: rtl/sync_edge_det.sv
// Two-flop synchroniser plus a previous-sample register for one asynchronous bus line.
// Everything resets to 1 so an idle-high bus never produces a phantom edge at reset release.
module sync_edge_det (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  logic meta_q;
  logic sync_q;
  logic prev_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
      prev_q <= 1'b1;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign level_o = sync_q;
  assign rise_o  = sync_q & ~prev_q;
  assign fall_o  = ~sync_q & prev_q;

endmodule

// File: rtl/serial_onehot_rx.sv
// Serial frame receiver: START, DATA_W bits MSB-first on scl rising edges, STOP.
// A good frame is presented on dout either one-hot decoded or as the raw payload.
module serial_onehot_rx
  import serial_onehot_rx_pkg::*;
#(
  parameter int DATA_W  = 4,
  parameter int MODE    = 0,
  parameter int TIMEOUT = 1024
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 scl,
  input  logic                 sda,
  output logic [2**DATA_W-1:0] dout,
  output logic                 frame_valid,
  output logic                 frame_err,
  output logic                 busy
);

  localparam int OUT_W = 2**DATA_W;
  localparam int TW    = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

  logic sclLevel, sclRise, sclFall;
  logic sdaLevel, sdaRise, sdaFall;

  sync_edge_det u_scl_sync (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .d_i    (scl),
    .level_o(sclLevel),
    .rise_o (sclRise),
    .fall_o (sclFall)
  );

  sync_edge_det u_sda_sync (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .d_i    (sda),
    .level_o(sdaLevel),
    .rise_o (sdaRise),
    .fall_o (sdaFall)
  );

  logic sclStableHigh, startEv, stopEv, sdaBit, tmoHit;

  // An sda edge coinciding with an scl edge is ignored, so the sampled bit is the pre-edge sda level.
  assign sclStableHigh = sclLevel & ~sclRise & ~sclFall;
  assign startEv       = sdaFall & sclStableHigh;
  assign stopEv        = sdaRise & sclStableHigh;
  assign sdaBit        = sdaLevel ^ (sdaRise | sdaFall);

  state_e            state_q, state_d;
  logic [3:0]        bitCnt_q, bitCnt_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [TW-1:0]     tmoCnt_q, tmoCnt_d;
  logic [OUT_W-1:0]  dout_q, dout_d;
  logic              valid_q, valid_d;
  logic              err_q, err_d;
  logic [OUT_W-1:0]  result;

  assign tmoHit = (TIMEOUT != 0) && (tmoCnt_q == TW'(TIMEOUT - 1));

  always_comb begin
    result = '0;
    if (MODE == MODE_RAW) begin
      result = OUT_W'(shift_q);
    end else begin
      result[shift_q] = 1'b1;
    end
  end

  always_comb begin
    state_d  = state_q;
    bitCnt_d = bitCnt_q;
    shift_d  = shift_q;
    tmoCnt_d = tmoCnt_q;
    dout_d   = dout_q;
    valid_d  = 1'b0;
    err_d    = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (startEv) begin
          state_d  = ST_RECV;
          bitCnt_d = '0;
          shift_d  = '0;
          tmoCnt_d = '0;
        end
      end

      ST_RECV: begin
        if (startEv) begin
          bitCnt_d = '0;
          shift_d  = '0;
          tmoCnt_d = '0;
        end else if (stopEv) begin
          err_d   = 1'b1;
          state_d = ST_IDLE;
        end else if (sclRise) begin
          shift_d  = DATA_W'({shift_q, sdaBit});
          bitCnt_d = bitCnt_q + 4'd1;
          tmoCnt_d = '0;
          if (bitCnt_q + 4'd1 == 4'(DATA_W)) begin
            state_d = ST_WAIT_STOP;
          end
        end else if (tmoHit) begin
          err_d   = 1'b1;
          state_d = ST_IDLE;
        end else begin
          tmoCnt_d = tmoCnt_q + TW'(1);
        end
      end

      ST_WAIT_STOP: begin
        if (startEv) begin
          state_d  = ST_RECV;
          bitCnt_d = '0;
          shift_d  = '0;
          tmoCnt_d = '0;
        end else if (stopEv) begin
          dout_d  = result;
          valid_d = 1'b1;
          state_d = ST_IDLE;
        end else if (sclRise) begin
          err_d   = 1'b1;
          state_d = ST_DISCARD;
        end else if (tmoHit) begin
          err_d   = 1'b1;
          state_d = ST_IDLE;
        end else begin
          tmoCnt_d = tmoCnt_q + TW'(1);
        end
      end

      ST_DISCARD: begin
        if (stopEv) begin
          state_d = ST_IDLE;
        end else if (startEv) begin
          state_d  = ST_RECV;
          bitCnt_d = '0;
          shift_d  = '0;
          tmoCnt_d = '0;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      bitCnt_q <= '0;
      shift_q  <= '0;
      tmoCnt_q <= '0;
      dout_q   <= '0;
      valid_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      bitCnt_q <= bitCnt_d;
      shift_q  <= shift_d;
      tmoCnt_q <= tmoCnt_d;
      dout_q   <= dout_d;
      valid_q  <= valid_d;
      err_q    <= err_d;
    end
  end

  assign dout        = dout_q;
  assign frame_valid = valid_q;
  assign frame_err   = err_q;
  assign busy        = (state_q != ST_IDLE);

endmodule

// File: tb/tb_serial_onehot_rx.sv
// Bench for serial_onehot_rx: one-hot and raw instances share the bus and are checked
// against a frame-level model (bits counted after the last START, payload by arithmetic).
module tb_serial_onehot_rx;

  localparam int DATA_W  = 4;
  localparam int TIMEOUT = 64;
  localparam int HALF    = 8;
  localparam int OUT_W   = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic scl = 1'b1;
  logic sda = 1'b1;

  logic [OUT_W-1:0] dout0, dout1;
  logic fv0, fe0, busy0, fv1, fe1, busy1;

  int checks = 0;
  int failures = 0;
  int validCnt0 = 0, errCnt0 = 0, validCnt1 = 0, errCnt1 = 0, overlapCnt = 0;
  logic [OUT_W-1:0] expDout0 = '0, expDout1 = '0;

  serial_onehot_rx #(.DATA_W(DATA_W), .MODE(0), .TIMEOUT(TIMEOUT)) dut0 (
    .clk(clk), .rst_n(rst_n), .scl(scl), .sda(sda),
    .dout(dout0), .frame_valid(fv0), .frame_err(fe0), .busy(busy0)
  );

  serial_onehot_rx #(.DATA_W(DATA_W), .MODE(1), .TIMEOUT(TIMEOUT)) dut1 (
    .clk(clk), .rst_n(rst_n), .scl(scl), .sda(sda),
    .dout(dout1), .frame_valid(fv1), .frame_err(fe1), .busy(busy1)
  );

  always #5 clk = ~clk;

  // Pulse monitor, sampled on the inactive edge.
  always @(negedge clk) begin
    if (fv0) validCnt0++;
    if (fe0) errCnt0++;
    if (fv1) validCnt1++;
    if (fe1) errCnt1++;
    if ((fv0 && fe0) || (fv1 && fe1)) overlapCnt++;
  end

  // Reference: payload as an integer, then shifted or zero-extended with plain arithmetic.
  function automatic logic [OUT_W-1:0] modelDout(input int payload, input int mode);
    if (mode == 0) return OUT_W'(1) << payload;
    return OUT_W'(payload);
  endfunction

  task automatic waitClk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic sendStart();
    if (!(scl && sda)) begin
      scl = 1'b0;
      waitClk(HALF / 2);
      sda = 1'b1;
      waitClk(HALF / 2);
      scl = 1'b1;
      waitClk(HALF);
    end
    sda = 1'b0;
    waitClk(HALF);
  endtask

  // The last bit drops sda together with the scl rise so a STOP can follow without another clock.
  task automatic sendBit(input logic b, input bit last);
    scl = 1'b0;
    waitClk(HALF / 2);
    sda = b;
    waitClk(HALF / 2);
    scl = 1'b1;
    if (last) sda = 1'b0;
    waitClk(HALF);
  endtask

  task automatic sendBits(input logic [7:0] bits, input int n);
    for (int i = 0; i < n; i++) sendBit(bits[n-1-i], i == n - 1);
  endtask

  task automatic sendStop();
    sda = 1'b1;
    waitClk(2 * HALF);
  endtask

  task automatic test_reset();
    waitClk(3);
    checks++;
    if ({dout0, dout1, fv0, fe0, busy0, fv1, fe1, busy1} !== '0) begin
      failures++;
      $display("[TB] FAIL reset_outputs: got %h/%h flags %b%b%b%b%b%b required all zero",
               dout0, dout1, fv0, fe0, busy0, fv1, fe1, busy1);
    end
    rst_n = 1'b1;
    waitClk(6);
    checks++;
    if ({busy0, busy1} !== 2'b00 || (validCnt0 + errCnt0 + validCnt1 + errCnt1) != 0) begin
      failures++;
      $display("[TB] FAIL reset_release: busy %b%b pulses %0d required idle and 0",
               busy0, busy1, validCnt0 + errCnt0 + validCnt1 + errCnt1);
    end
  endtask

  task automatic test_onehot_basic();
    int v0 = validCnt0, e0 = errCnt0;
    sendStart();
    checks++;
    if (busy0 !== 1'b1) begin
      failures++;
      $display("[TB] FAIL busy_after_start: got %b required 1", busy0);
    end
    sendBits(8'b1010, 4);
    sda = 1'b1;
    waitClk(2);
    checks++;
    if (fv0 !== 1'b0) begin
      failures++;
      $display("[TB] FAIL stop_latency_early: frame_valid %b after 2 edges required 0", fv0);
    end
    waitClk(1);
    checks++;
    if (fv0 !== 1'b1 || dout0 !== modelDout(10, 0)) begin
      failures++;
      $display("[TB] FAIL stop_latency: valid %b dout %h after 3 edges required 1 and %h",
               fv0, dout0, modelDout(10, 0));
    end
    waitClk(2 * HALF);
    expDout0 = modelDout(10, 0);
    expDout1 = modelDout(10, 1);
    checks++;
    if (validCnt0 - v0 != 1 || errCnt0 != e0 || busy0 !== 1'b0 || dout1 !== expDout1) begin
      failures++;
      $display("[TB] FAIL frame_1010: valid %0d err %0d busy %b raw %h required 1 0 0 %h",
               validCnt0 - v0, errCnt0 - e0, busy0, dout1, expDout1);
    end
  endtask

  task automatic test_raw_mode();
    int v1 = validCnt1;
    sendStart();
    sendBits(8'b1111, 4);
    sendStop();
    expDout0 = modelDout(15, 0);
    expDout1 = modelDout(15, 1);
    checks++;
    if (dout1 !== expDout1 || dout0 !== expDout0 || validCnt1 - v1 != 1) begin
      failures++;
      $display("[TB] FAIL frame_1111: raw %h onehot %h valid %0d required %h %h 1",
               dout1, dout0, validCnt1 - v1, expDout1, expDout0);
    end
  endtask

  task automatic test_short_frame();
    int v0 = validCnt0, e0 = errCnt0, e1 = errCnt1;
    sendStart();
    sendBits(8'b110, 3);
    sendStop();
    checks++;
    if (errCnt0 - e0 != 1 || errCnt1 - e1 != 1 || validCnt0 != v0 ||
        dout0 !== expDout0 || dout1 !== expDout1 || busy0 !== 1'b0) begin
      failures++;
      $display("[TB] FAIL short_frame: err %0d/%0d valid %0d dout %h/%h required 1/1 0 %h/%h",
               errCnt0 - e0, errCnt1 - e1, validCnt0 - v0, dout0, dout1, expDout0, expDout1);
    end
  endtask

  task automatic test_repeated_start();
    int v0 = validCnt0, e0 = errCnt0;
    sendStart();
    sendBit(1'b1, 1'b0);
    sendBit(1'b1, 1'b0);
    sendStart();
    sendBits(8'b0011, 4);
    sendStop();
    expDout0 = modelDout(3, 0);
    expDout1 = modelDout(3, 1);
    checks++;
    if (dout0 !== expDout0 || dout1 !== expDout1 || errCnt0 != e0 || validCnt0 - v0 != 1) begin
      failures++;
      $display("[TB] FAIL repeated_start: dout %h/%h err %0d valid %0d required %h/%h 0 1",
               dout0, dout1, errCnt0 - e0, validCnt0 - v0, expDout0, expDout1);
    end
  endtask

  task automatic test_extra_bit();
    int v0 = validCnt0, e0 = errCnt0;
    sendStart();
    sendBits(8'b10110, 5);
    sendStop();
    checks++;
    if (errCnt0 - e0 != 1 || validCnt0 != v0 || dout0 !== expDout0 || busy0 !== 1'b0) begin
      failures++;
      $display("[TB] FAIL extra_bit: err %0d valid %0d dout %h busy %b required 1 0 %h 0",
               errCnt0 - e0, validCnt0 - v0, dout0, busy0, expDout0);
    end
  endtask

  task automatic test_timeout();
    int e0 = errCnt0, v0 = validCnt0;
    int errAt = -1;
    sendStart();
    sendBit(1'b1, 1'b0);
    scl = 1'b0;
    waitClk(HALF / 2);
    sda = 1'b1;
    waitClk(HALF / 2);
    scl = 1'b1;
    for (int i = 1; i <= 100; i++) begin
      @(negedge clk);
      if (fe0 && errAt < 0) errAt = i;
    end
    checks++;
    if (errAt < TIMEOUT || errAt > TIMEOUT + 4) begin
      failures++;
      $display("[TB] FAIL timeout_cycle: frame_err at %0d clk required %0d..%0d",
               errAt, TIMEOUT, TIMEOUT + 4);
    end
    checks++;
    if (busy0 !== 1'b0 || errCnt0 - e0 != 1 || validCnt0 != v0 || dout0 !== expDout0) begin
      failures++;
      $display("[TB] FAIL timeout_state: busy %b err %0d valid %0d dout %h required 0 1 0 %h",
               busy0, errCnt0 - e0, validCnt0 - v0, dout0, expDout0);
    end
  endtask

  task automatic test_reset_mid_frame();
    int v0, e0;
    sendStart();
    sendBit(1'b1, 1'b0);
    sendBit(1'b1, 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({dout0, dout1, fv0, fe0, busy0, fv1, fe1, busy1} !== '0) begin
      failures++;
      $display("[TB] FAIL reset_mid_frame: got %h/%h busy %b%b required all zero",
               dout0, dout1, busy0, busy1);
    end
    expDout0 = '0;
    expDout1 = '0;
    waitClk(2);
    rst_n = 1'b1;
    waitClk(4);
    v0 = validCnt0;
    e0 = errCnt0;
    sendStart();
    sendBits(8'b0101, 4);
    sendStop();
    expDout0 = modelDout(5, 0);
    expDout1 = modelDout(5, 1);
    checks++;
    if (dout0 !== expDout0 || dout1 !== expDout1 || validCnt0 - v0 != 1 || errCnt0 != e0) begin
      failures++;
      $display("[TB] FAIL frame_after_reset: dout %h/%h valid %0d err %0d required %h/%h 1 0",
               dout0, dout1, validCnt0 - v0, errCnt0 - e0, expDout0, expDout1);
    end
  endtask

  task automatic test_random_frames();
    for (int it = 0; it < 16; it++) begin
      int kind = $urandom_range(0, 3);
      int n = 4;
      int payload = 0;
      logic [7:0] bits = 8'($urandom_range(0, 255));
      int v0 = validCnt0, e0 = errCnt0, v1 = validCnt1, e1 = errCnt1;
      bit good;
      sendStart();
      if (kind == 1) n = $urandom_range(1, 3);
      if (kind == 2) n = $urandom_range(5, 7);
      if (kind == 3) begin
        int k = $urandom_range(1, 3);
        for (int j = 0; j < k - 1; j++) sendBit(1'($urandom_range(0, 1)), 1'b0);
        sendBit(1'b1, 1'b0);
        sendStart();
      end
      sendBits(bits, n);
      sendStop();
      good = (n == DATA_W);
      for (int j = 0; j < n; j++) payload = payload * 2 + int'(bits[n-1-j]);
      if (good) begin
        expDout0 = modelDout(payload, 0);
        expDout1 = modelDout(payload, 1);
      end
      checks++;
      if (validCnt0 - v0 != int'(good) || validCnt1 - v1 != int'(good) ||
          errCnt0 - e0 != int'(!good) || errCnt1 - e1 != int'(!good) ||
          dout0 !== expDout0 || dout1 !== expDout1 || busy0 !== 1'b0) begin
        failures++;
        $display("[TB] FAIL random_%0d kind %0d n %0d: valid %0d err %0d dout %h/%h required %0d %0d %h/%h",
                 it, kind, n, validCnt0 - v0, errCnt0 - e0, dout0, dout1,
                 int'(good), int'(!good), expDout0, expDout1);
      end
    end
  endtask

  task automatic test_no_overlap();
    checks++;
    if (overlapCnt != 0) begin
      failures++;
      $display("[TB] FAIL valid_err_overlap: %0d cycles required 0", overlapCnt);
    end
  endtask

  initial begin
    test_reset();
    test_onehot_basic();
    test_raw_mode();
    test_short_frame();
    test_repeated_start();
    test_extra_bit();
    test_timeout();
    test_reset_mid_frame();
    test_random_frames();
    test_no_overlap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/serial_onehot_rx.md
SERIAL_ONEHOT_RX -- requirements
Module: serial_onehot_rx

Interface
REQ-001 Parameter DATA_W, default 4, payload bits per frame (1..8).
REQ-002 Parameter MODE, default 0, output mode: 0 = one-hot decode of payload, 1 = raw binary payload zero-extended.
REQ-003 Parameter TIMEOUT, default 1024, clk cycles without an scl rising edge in a frame before abort (0 disables).
REQ-004 Port clk  input  1  single system clock; all state changes on its rising edge.
REQ-005 Port rst_n  input  1  reset; asynchronous, active-low.
REQ-006 Port scl  input  1  serial clock, asynchronous to clk, idle high.
REQ-007 Port sda  input  1  serial data, asynchronous to clk, idle high.
REQ-008 Port dout  output  2**DATA_W  last good frame result, held until the next good frame.
REQ-009 Port frame_valid  output  1  one-clk pulse when dout is updated.
REQ-010 Port frame_err  output  1  one-clk pulse on a malformed or aborted frame.
REQ-011 Port busy  output  1  high while state is not IDLE.

Function
REQ-012 scl and sda SHALL each pass through a 2-FF synchroniser; all detection uses the synchronised values plus one registered previous value.
REQ-013 START = sda falls while scl is high in both the current and previous synchronised samples.
REQ-014 STOP = sda rises while scl is high in both the current and previous synchronised samples.
REQ-015 If scl and sda change in the same synchronised sample, only the scl edge is recognised; no START or STOP is recognised.
REQ-016 States: IDLE, RECV, WAIT_STOP, DISCARD.
REQ-017 IDLE: START -> RECV, bit counter = 0, shift register = 0; all other events are ignored.
REQ-018 RECV: each scl rising edge shifts sda in MSB-first and increments the counter; when the counter reaches DATA_W -> WAIT_STOP.
REQ-019 RECV: STOP before DATA_W bits -> pulse frame_err, go to IDLE, dout unchanged.
REQ-020 WAIT_STOP: STOP -> register dout, pulse frame_valid in the same cycle, go to IDLE.
REQ-021 WAIT_STOP: an scl rising edge (extra bit) -> pulse frame_err, go to DISCARD.
REQ-022 DISCARD: STOP -> IDLE with no further pulse; START -> RECV.
REQ-023 A START in RECV or WAIT_STOP (repeated start) -> clear counter and shift register, stay in or enter RECV, no frame_err.
REQ-024 MODE 0: dout = 1 << payload. MODE 1: dout = payload zero-extended to 2**DATA_W bits.
REQ-025 Timeout counter clears on every scl rising edge and on entry to RECV; it counts in RECV and WAIT_STOP only.
REQ-026 Timeout reaching TIMEOUT -> pulse frame_err, go to IDLE, dout unchanged.
REQ-027 Latency: a raw sda edge completing STOP appears on dout/frame_valid 3 clk edges later, given scl is already stable high.
REQ-028 frame_valid and frame_err SHALL never be high in the same cycle.

Reset
REQ-029 Asserting rst_n low SHALL immediately force: state IDLE; dout 0; frame_valid 0; frame_err 0; busy 0; counters 0.
REQ-030 Synchroniser and previous-sample registers reset to 1 (bus idle), so release of reset creates no false START or STOP.
REQ-031 Reset during a frame abandons the frame; after release the block waits for a new START.

Structure
REQ-032 Package serial_onehot_rx_pkg holds the state enum and the MODE_ONEHOT = 0 and MODE_RAW = 1 constants.
REQ-033 Sub-module sync_edge_det (2-FF synchroniser, previous-value register, rise/fall flags, async active-low reset to 1) is instantiated once each for scl and sda.

Verification (DATA_W=4, TIMEOUT=64, scl half-period 8 clk)
REQ-034 MODE 0: START, bits 1,0,1,0, STOP -> dout=16'h0400, frame_valid one pulse, busy low afterwards.
REQ-035 MODE 1: same frame -> dout=16'h000A; next frame 1,1,1,1 -> dout=16'h000F.
REQ-036 Short frame: START, bits 1,1,0, STOP -> frame_err pulse, dout keeps its previous value, no frame_valid.
REQ-037 Repeated start: START, bits 1,1, START, bits 0,0,1,1, STOP in MODE 0 -> dout=16'h0008, no frame_err.
REQ-038 Extra bit then timeout: 5 bits then STOP -> one frame_err and dout unchanged; separately, START, 2 bits, scl held 70 clk -> frame_err at cycle 64, state IDLE.
REQ-039 rst_n pulsed low mid-frame after 2 bits -> outputs 0 at once; a full following frame 0,1,0,1 decodes to 16'h0020.
